lift_car_drive: RTL
===================

LIFT_CAR_DRIVE -- requirements
Module: lift_car_drive

Interface
REQ-001 SHALL have parameter N_FLOORS, default 8, number of served floors (2..32).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 16, cycles to move one floor (>=2).
REQ-003 SHALL have parameter DOOR_CYCLES, default 8, cycles per door phase (>=2).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_direction  input  1  requested direction, 0=up, 1=down.
REQ-007 SHALL have port i_motion  input  1  move request from the scheduler.
REQ-008 SHALL have port i_has_rqst_at_stopped_flr  input  1  request pending at the current floor while stopped.
REQ-009 SHALL have port i_door_obstruct  input  1  door obstruction sensor.
REQ-010 SHALL have port o_flr_pos  output  N_FLOORS  one-hot car floor; all zeros while between floors.
REQ-011 SHALL have port o_flr_idx  output  $clog2(N_FLOORS)  binary index of the last floor reached.
REQ-012 SHALL have port o_door_open  output  1  high during the DOOR_OPEN phase.
REQ-013 SHALL have port o_door_closing  output  1  high during the DOOR_CLOSE phase.
REQ-014 SHALL have port o_moving  output  1  high during TRAVEL.
REQ-015 SHALL have port o_limit_err  output  1  one-cycle pulse on an illegal move request.

Function
REQ-016 SHALL implement FSM states STOPPED, TRAVEL, DOOR_OPEN, DOOR_CLOSE; all outputs registered.
REQ-017 In STOPPED with i_motion=1: legal move -> TRAVEL next cycle, latch i_direction, clear timer; i_motion has priority over i_has_rqst_at_stopped_flr.
REQ-018 Illegal move = up at index N_FLOORS-1 or down at index 0 -> stay STOPPED, o_limit_err=1 for exactly one cycle per requesting cycle, index unchanged.
REQ-019 In STOPPED with i_motion=0 and i_has_rqst_at_stopped_flr=1 -> DOOR_OPEN next cycle, timer cleared.
REQ-020 In TRAVEL: o_flr_pos=0 and o_moving=1 for exactly TRAVEL_CYCLES cycles; i_direction, i_motion, i_has_rqst_at_stopped_flr ignored.
REQ-021 At TRAVEL timer = TRAVEL_CYCLES-1: index += 1 (up) or -= 1 (down); next cycle state STOPPED, o_flr_pos = one-hot(new index), o_moving=0.
REQ-022 Index SHALL never wrap; it saturates within 0..N_FLOORS-1 by construction of REQ-018.
REQ-023 DOOR_OPEN: o_door_open=1 for DOOR_CYCLES cycles, then DOOR_CLOSE: o_door_closing=1 for DOOR_CYCLES cycles, then STOPPED.
REQ-024 In DOOR_OPEN/DOOR_CLOSE, i_motion SHALL be ignored; o_flr_pos holds one-hot(index).
REQ-025 Timer SHALL be $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1) bits wide, reset to 0 on every state entry.

Reset
REQ-026 On reset=1: state STOPPED, index 0, o_flr_pos=one-hot(0), o_flr_idx=0, timer 0, o_door_open=0, o_door_closing=0, o_moving=0, o_limit_err=0.
REQ-027 Reset asserted mid-TRAVEL or mid-door SHALL override all state on the same edge; no floor increment completes.

Configuration
REQ-028 Macro DOOR_REOPEN_EN defined: i_door_obstruct=1 in DOOR_CLOSE -> DOOR_OPEN next cycle, timer cleared (full reopen); obstruct in other states ignored.
REQ-029 Macro DOOR_REOPEN_EN undefined: i_door_obstruct SHALL be ignored in all states; port still present.

Verification (N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-030 Reset 1 cycle -> o_flr_pos=8'h01, o_flr_idx=0, all status outputs 0.
REQ-031 Floor 0, i_direction=0, i_motion=1 one cycle -> o_flr_pos=8'h00 and o_moving=1 for 4 cycles, then o_flr_pos=8'h02, o_flr_idx=1.
REQ-032 Floor 0, i_direction=1, i_motion=1 one cycle -> o_limit_err pulse 1 cycle, o_flr_pos stays 8'h01; same at floor 7 with i_direction=0.
REQ-033 Floor 2, i_has_rqst_at_stopped_flr=1 -> o_door_open 3 cycles, o_door_closing 3 cycles, then STOPPED; i_motion=1 during doors causes no travel until STOPPED.
REQ-034 i_door_obstruct=1 in 2nd DOOR_CLOSE cycle -> with DOOR_REOPEN_EN: o_door_open 3 more cycles; without: closing completes after 3 cycles total.
REQ-035 Reset at 2nd TRAVEL cycle from floor 3 -> next cycle o_flr_pos=8'h01, o_moving=0, o_flr_idx=0.

Source files
------------

// File: rtl/lift_car_drive.sv
// rtl/lift_car_drive.sv - lift car floor/door sequencer; optional DOOR_REOPEN_EN enables obstruction reopen
module lift_car_drive #(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_direction,
    input  logic                        i_motion,
    input  logic                        i_has_rqst_at_stopped_flr,
    input  logic                        i_door_obstruct,
    output logic [N_FLOORS-1:0]         o_flr_pos,
    output logic [$clog2(N_FLOORS)-1:0] o_flr_idx,
    output logic                        o_door_open,
    output logic                        o_door_closing,
    output logic                        o_moving,
    output logic                        o_limit_err
);

    localparam int IW      = $clog2(N_FLOORS);
    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]       TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]       DOOR_LAST   = TW'(DOOR_CYCLES - 1);
    localparam logic [IW-1:0]       TOP_IDX     = IW'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] POS_FLOOR0  = N_FLOORS'(1);

    typedef enum logic [1:0] {
        ST_STOPPED    = 2'd0,
        ST_TRAVEL     = 2'd1,
        ST_DOOR_OPEN  = 2'd2,
        ST_DOOR_CLOSE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       timer_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic                dir;
    logic                dir_next;
    logic                move_legal;
    logic                reopen_req;
    logic                limit_err_next;
    logic [N_FLOORS-1:0] flr_pos_next;
    logic                door_open_next;
    logic                door_closing_next;
    logic                moving_next;

`ifdef DOOR_REOPEN_EN
    assign reopen_req = i_door_obstruct;
`else
    // Obstruction sensor is wired but inert in this build.
    assign reopen_req = 1'b0 & i_door_obstruct;
`endif

    // A move off either end of the shaft is refused, which keeps idx in range.
    assign move_legal = i_direction ? (idx != '0) : (idx != TOP_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_STOPPED;
            timer          <= '0;
            idx            <= '0;
            dir            <= 1'b0;
            o_flr_pos      <= POS_FLOOR0;
            o_door_open    <= 1'b0;
            o_door_closing <= 1'b0;
            o_moving       <= 1'b0;
            o_limit_err    <= 1'b0;
        end else begin
            state          <= state_next;
            timer          <= timer_next;
            idx            <= idx_next;
            dir            <= dir_next;
            o_flr_pos      <= flr_pos_next;
            o_door_open    <= door_open_next;
            o_door_closing <= door_closing_next;
            o_moving       <= moving_next;
            o_limit_err    <= limit_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        timer_next     = timer + TW'(1);
        idx_next       = idx;
        dir_next       = dir;
        limit_err_next = 1'b0;
        case (state)
            ST_STOPPED: begin
                timer_next = '0;
                if (i_motion) begin
                    if (move_legal) begin
                        state_next = ST_TRAVEL;
                        dir_next   = i_direction;
                    end else begin
                        limit_err_next = 1'b1;
                    end
                end else if (i_has_rqst_at_stopped_flr) begin
                    state_next = ST_DOOR_OPEN;
                end
            end
            ST_TRAVEL: begin
                if (timer == TRAVEL_LAST) begin
                    state_next = ST_STOPPED;
                    timer_next = '0;
                    idx_next   = dir ? (idx - IW'(1)) : (idx + IW'(1));
                end
            end
            ST_DOOR_OPEN: begin
                if (timer == DOOR_LAST) begin
                    state_next = ST_DOOR_CLOSE;
                    timer_next = '0;
                end
            end
            ST_DOOR_CLOSE: begin
                // An obstruction restarts the full open phase, even on the last closing cycle.
                if (reopen_req) begin
                    state_next = ST_DOOR_OPEN;
                    timer_next = '0;
                end else if (timer == DOOR_LAST) begin
                    state_next = ST_STOPPED;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = ST_STOPPED;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        flr_pos_next      = '0;
        door_open_next    = 1'b0;
        door_closing_next = 1'b0;
        moving_next       = 1'b0;
        if (state_next != ST_TRAVEL) begin
            flr_pos_next = POS_FLOOR0 << idx_next;
        end
        case (state_next)
            ST_TRAVEL:     moving_next       = 1'b1;
            ST_DOOR_OPEN:  door_open_next    = 1'b1;
            ST_DOOR_CLOSE: door_closing_next = 1'b1;
            default:       ;
        endcase
    end

    assign o_flr_idx = idx;

endmodule
